// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/arith/shift ops, shift-add multiply, restoring divide.
// Define ALU_DIV_EN to build the divider; without it DIV/DIVU report as illegal ops.
module multicycle_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] wrk_q, wrk_d;
  logic [WIDTH-1:0] opd_q, opd_d;
  logic             pneg_q, pneg_d;
`ifdef ALU_DIV_EN
  logic             rneg_q, rneg_d;
  logic             isdiv_q, isdiv_d;
`endif
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;
  logic             done_q, done_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] alu_res;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
`ifdef ALU_DIV_EN
  logic [WIDTH:0]   rem_sh, div_diff;
  logic [WIDTH-1:0] quo_fix, rem_fix;
`endif

  // Both units work on magnitudes; op[0]=0 marks the signed variants (MULT, DIV).
  assign a_neg = ~op[0] & a[WIDTH-1];
  assign b_neg = ~op[0] & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;
  assign shamt = b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    unique case (op)
      4'b0000: alu_res = a & b;
      4'b0001: alu_res = a | b;
      4'b0010: alu_res = a + b;
      4'b0011: alu_res = a ^ b;
      4'b0100: alu_res = ~(a | b);
      4'b0101: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      4'b0110: alu_res = a - b;
      4'b0111: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'b1000: alu_res = a << shamt;
      4'b1001: alu_res = a >> shamt;
      4'b1010: alu_res = $unsigned($signed(a) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  assign mul_sum  = {1'b0, acc_q} + {1'b0, opd_q & {WIDTH{wrk_q[0]}}};
  assign prod_raw = {acc_q, wrk_q};
  assign prod_fix = pneg_q ? -prod_raw : prod_raw;
`ifdef ALU_DIV_EN
  assign rem_sh   = {acc_q, wrk_q[WIDTH-1]};
  assign div_diff = rem_sh - {1'b0, opd_q};
  assign quo_fix  = pneg_q ? -wrk_q : wrk_q;
  assign rem_fix  = rneg_q ? -acc_q : acc_q;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    wrk_d    = wrk_q;
    opd_d    = opd_q;
    pneg_d   = pneg_q;
`ifdef ALU_DIV_EN
    rneg_d   = rneg_q;
    isdiv_d  = isdiv_q;
`endif
    result_d = result_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    zero_d   = zero_q;
    err_d    = err_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (op[3:2] != 2'b11) begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            err_d    = (op == 4'b1011);
            done_d   = 1'b1;
          end else if (!op[1]) begin
            acc_d   = '0;
            wrk_d   = a_mag;
            opd_d   = b_mag;
            pneg_d  = a_neg ^ b_neg;
            cnt_d   = '0;
`ifdef ALU_DIV_EN
            isdiv_d = 1'b0;
`endif
            state_d = MUL;
          end else begin
`ifdef ALU_DIV_EN
            if (b == '0) begin
              result_d = '1;
              zero_d   = 1'b0;
              lo_d     = '1;
              hi_d     = a;
              err_d    = 1'b1;
              done_d   = 1'b1;
            end else begin
              acc_d   = '0;
              wrk_d   = a_mag;
              opd_d   = b_mag;
              pneg_d  = a_neg ^ b_neg;
              rneg_d  = a_neg;
              cnt_d   = '0;
              isdiv_d = 1'b1;
              state_d = DIV;
            end
`else
            result_d = '0;
            zero_d   = 1'b1;
            err_d    = 1'b1;
            done_d   = 1'b1;
`endif
          end
        end
      end

      MUL: begin
        // Add-then-shift: the carry lands in acc MSB, the dropped acc LSB enters wrk.
        acc_d = mul_sum[WIDTH:1];
        wrk_d = {mul_sum[0], wrk_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = FIX;
        end
      end

`ifdef ALU_DIV_EN
      DIV: begin
        acc_d = div_diff[WIDTH] ? rem_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
        wrk_d = {wrk_q[WIDTH-2:0], ~div_diff[WIDTH]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = FIX;
        end
      end
`endif

      FIX: begin
`ifdef ALU_DIV_EN
        if (isdiv_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
`else
        {hi_d, lo_d} = prod_fix;
`endif
        result_d = lo_d;
        zero_d   = (lo_d == '0);
        err_d    = 1'b0;
        done_d   = 1'b1;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      wrk_q    <= '0;
      opd_q    <= '0;
      pneg_q   <= 1'b0;
`ifdef ALU_DIV_EN
      rneg_q   <= 1'b0;
      isdiv_q  <= 1'b0;
`endif
      result_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      zero_q   <= 1'b1;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      wrk_q    <= wrk_d;
      opd_q    <= opd_d;
      pneg_q   <= pneg_d;
`ifdef ALU_DIV_EN
      rneg_q   <= rneg_d;
      isdiv_q  <= isdiv_d;
`endif
      result_q <= result_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign zero   = zero_q;
  assign hi     = hi_q;
  assign lo     = lo_q;
  assign err    = err_q;
  assign done   = done_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_multicycle_alu.sv
// Randomized bench for multicycle_alu (WIDTH=32) against a plain-arithmetic reference model.
// Expectations for DIV/DIVU follow ALU_DIV_EN as defined for the build.
module tb_multicycle_alu;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] a, b;
  logic [W-1:0] result, hi, lo;
  logic         zero, busy, done, err;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  logic [W-1:0] m_hi, m_lo, e_res;
  logic         e_err;
  int unsigned  e_lat;

  multicycle_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .result(result), .zero(zero), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: full-width products/quotients via 64-bit arithmetic.
  task automatic model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint       sx, sy;
    logic [63:0]  p, q, r;
    logic [4:0]   sh;
    sx    = longint'($signed(x));
    sy    = longint'($signed(y));
    sh    = y[4:0];
    e_err = 1'b0;
    e_lat = 1;
    case (o)
      4'd0:  e_res = x & y;
      4'd1:  e_res = x | y;
      4'd2:  e_res = x + y;
      4'd3:  e_res = x ^ y;
      4'd4:  e_res = ~(x | y);
      4'd5:  e_res = {31'b0, (x < y)};
      4'd6:  e_res = x - y;
      4'd7:  e_res = {31'b0, (sx < sy)};
      4'd8:  e_res = x << sh;
      4'd9:  e_res = x >> sh;
      4'd10: e_res = W'(sx >>> sh);
      4'd12: begin
        p = sx * sy;
        m_hi = p[63:32]; m_lo = p[31:0]; e_res = m_lo; e_lat = W + 2;
      end
      4'd13: begin
        p = {32'b0, x} * {32'b0, y};
        m_hi = p[63:32]; m_lo = p[31:0]; e_res = m_lo; e_lat = W + 2;
      end
      4'd14, 4'd15: begin
`ifdef ALU_DIV_EN
        if (y == '0) begin
          m_lo = '1; m_hi = x; e_res = '1; e_err = 1'b1;
        end else begin
          if (o == 4'd14) begin
            q = sx / sy; r = sx % sy;
          end else begin
            q = {32'b0, x} / {32'b0, y}; r = {32'b0, x} % {32'b0, y};
          end
          m_lo = q[31:0]; m_hi = r[31:0]; e_res = m_lo; e_lat = W + 2;
        end
`else
        e_res = '0; e_err = 1'b1;
`endif
      end
      default: begin
        e_res = '0; e_err = 1'b1;
      end
    endcase
  endtask

  task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int unsigned lat, bcnt;
    model(o, x, y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      // A stray request mid-operation must be ignored.
      if (lat == 3) begin
        start = 1'b1; op = 4'($urandom); a = $urandom; b = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk($sformatf("done op%0d", o), done, 1'b1);
    chk($sformatf("latency op%0d", o), lat, e_lat);
    chk($sformatf("busy_cycles op%0d", o), bcnt, (e_lat == 1) ? 0 : W + 1);
    chk($sformatf("busy_at_done op%0d", o), busy, 1'b0);
    chk($sformatf("result op%0d a=%h b=%h", o, x, y), result, e_res);
    chk($sformatf("zero op%0d", o), zero, (e_res == '0));
    chk($sformatf("hi op%0d a=%h b=%h", o, x, y), hi, m_hi);
    chk($sformatf("lo op%0d a=%h b=%h", o, x, y), lo, m_lo);
    chk($sformatf("err op%0d", o), err, e_err);
  endtask

  task automatic idle_gap();
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    chk("gap_done", done, 1'b0);
    chk("gap_result_held", result, e_res);
    chk("gap_hi_held", hi, m_hi);
    chk("gap_lo_held", lo, m_lo);
    chk("gap_err_held", err, e_err);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_result"}, result, '0);
    chk({tag, "_hi"}, hi, '0);
    chk({tag, "_lo"}, lo, '0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_zero"}, zero, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
  endtask

  function automatic logic [W-1:0] rnd_opd();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = '1;
      2:       v = 32'h8000_0000;
      3:       v = 32'd1;
      4:       v = W'($urandom_range(0, 15));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned seen;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    m_hi = '0; m_lo = '0; e_res = '0; e_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b0;

    // First start lands on the first edge after reset release.
    run_op(4'd2, 32'hFFFF_FFFF, 32'd1);
    chk("spec_add_wrap", result, 32'h0);
    run_op(4'd10, 32'h8000_0000, 32'd4);
    chk("spec_sra", result, 32'hF800_0000);
    run_op(4'd7, 32'hFFFF_FFFF, 32'd1);
    chk("spec_slt", result, 32'd1);
    run_op(4'd11, 32'h1234, 32'h5678);
    run_op(4'd12, 32'hFFFF_FFFD, 32'd7);
    chk("spec_mult_hi", hi, 32'hFFFF_FFFF);
    chk("spec_mult_lo", lo, 32'hFFFF_FFEB);
    run_op(4'd14, 32'hFFFF_FFF9, 32'd2);
    run_op(4'd15, 32'h0000_1234, 32'd0);
    run_op(4'd14, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(4'd14, 32'h0000_0055, 32'd0);
    run_op(4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle_gap();

    // Abort a multiply part-way through with an asynchronous reset.
    @(negedge clk);
    op = 4'd13; a = $urandom; b = $urandom; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_reset_state("abort");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_hi = '0; m_lo = '0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    chk("abort_no_done", seen, 0);
    run_op(4'd2, 32'd40, 32'd2);

    for (int i = 0; i < 150; i++) begin
      run_op(4'($urandom_range(0, 15)), rnd_opd(), rnd_opd());
      if ($urandom_range(0, 3) == 0) idle_gap();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
